// File: rtl/issue_select_queue.sv
// Out-of-order issue queue with CDB wakeup and per-port select that holds its choice while stalled.
// Define ISSUE_QUEUE_AGE_SEL_EN for oldest-first selection; default build picks the lowest index.
module issue_select_queue #(
  parameter int  DEPTH  = 16,
  parameter int  NUM_FU = 3,
  parameter int  PREG_W = 6,
  parameter int  ROB_W  = 6,
  parameter int  DATA_W = 32,
  localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [PREG_W-1:0]        alloc_dest,
  input  logic [PREG_W-1:0]        alloc_rs1,
  input  logic [PREG_W-1:0]        alloc_rs2,
  input  logic                     alloc_rs1_rdy,
  input  logic                     alloc_rs2_rdy,
  input  logic [DATA_W-1:0]        alloc_rs1_val,
  input  logic [DATA_W-1:0]        alloc_rs2_val,
  input  logic [6:0]               alloc_opcode,
  input  logic [DATA_W-1:0]        alloc_imm,
  input  logic [ROB_W-1:0]         alloc_rob,
  input  logic [FU_W-1:0]          alloc_fu,
  input  logic                     cdb_valid,
  input  logic [PREG_W-1:0]        cdb_tag,
  input  logic [DATA_W-1:0]        cdb_val,
  output logic [NUM_FU-1:0]        issue_valid,
  input  logic [NUM_FU-1:0]        issue_ready,
  output logic [NUM_FU*PREG_W-1:0] issue_dest,
  output logic [NUM_FU*DATA_W-1:0] issue_rs1_val,
  output logic [NUM_FU*DATA_W-1:0] issue_rs2_val,
  output logic [NUM_FU*7-1:0]      issue_opcode,
  output logic [NUM_FU*DATA_W-1:0] issue_imm,
  output logic [NUM_FU*ROB_W-1:0]  issue_rob,
  input  logic                     flush,
  output logic [CNT_W-1:0]         count,
  output logic                     full
);

  logic [DEPTH-1:0]  valid_q, rs1_rdy_q, rs2_rdy_q;
  logic [FU_W-1:0]   fu_q      [DEPTH];
  logic [PREG_W-1:0] dest_q    [DEPTH];
  logic [PREG_W-1:0] rs1_tag_q [DEPTH];
  logic [PREG_W-1:0] rs2_tag_q [DEPTH];
  logic [DATA_W-1:0] rs1_val_q [DEPTH];
  logic [DATA_W-1:0] rs2_val_q [DEPTH];
  logic [DATA_W-1:0] imm_q     [DEPTH];
  logic [6:0]        opcode_q  [DEPTH];
  logic [ROB_W-1:0]  rob_q     [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [NUM_FU-1:0] hold_q;
  logic [IDX_W-1:0]  hold_idx_q [NUM_FU];
`ifdef ISSUE_QUEUE_AGE_SEL_EN
  logic [DEPTH-1:0]  age_q [DEPTH];  // age_q[j][i] set: entry j is older than entry i
`endif

  logic              alloc_fire;
  logic [IDX_W-1:0]  free_idx;
  logic [DEPTH-1:0]  eligible, wake1, wake2, alloc_mask, issue_mask;
  logic              a_rs1_rdy, a_rs2_rdy;
  logic [DATA_W-1:0] a_rs1_val, a_rs2_val;
  logic [DEPTH-1:0]  port_elig [NUM_FU];
  logic [DEPTH-1:0]  port_pick [NUM_FU];
  logic [IDX_W-1:0]  sel_idx   [NUM_FU];
  logic [CNT_W-1:0]  issue_cnt;

  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign eligible    = valid_q & rs1_rdy_q & rs2_rdy_q;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  // Tag 0 is the hardwired zero register; a same-cycle CDB hit is captured at allocation.
  always_comb begin
    a_rs1_rdy = (alloc_rs1 == '0) || alloc_rs1_rdy || (cdb_valid && alloc_rs1 == cdb_tag);
    a_rs2_rdy = (alloc_rs2 == '0) || alloc_rs2_rdy || (cdb_valid && alloc_rs2 == cdb_tag);
    if (alloc_rs1 == '0)                                     a_rs1_val = '0;
    else if (!alloc_rs1_rdy && cdb_valid && alloc_rs1 == cdb_tag) a_rs1_val = cdb_val;
    else                                                     a_rs1_val = alloc_rs1_val;
    if (alloc_rs2 == '0)                                     a_rs2_val = '0;
    else if (!alloc_rs2_rdy && cdb_valid && alloc_rs2 == cdb_tag) a_rs2_val = cdb_val;
    else                                                     a_rs2_val = alloc_rs2_val;
  end

  always_comb begin
    wake1      = '0;
    wake2      = '0;
    alloc_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]      = valid_q[i] && !rs1_rdy_q[i] && cdb_valid && (rs1_tag_q[i] == cdb_tag);
      wake2[i]      = valid_q[i] && !rs2_rdy_q[i] && cdb_valid && (rs2_tag_q[i] == cdb_tag);
      alloc_mask[i] = alloc_fire && (free_idx == IDX_W'(i));
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_FU; p++) begin
      port_elig[p] = '0;
      for (int i = 0; i < DEPTH; i++)
        port_elig[p][i] = eligible[i] && (fu_q[i] == FU_W'(p));
    end
  end

  // With age selection only the single oldest eligible entry survives; otherwise all do.
  always_comb begin
    for (int p = 0; p < NUM_FU; p++) begin
      port_pick[p] = port_elig[p];
`ifdef ISSUE_QUEUE_AGE_SEL_EN
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (port_elig[p][j] && age_q[j][i]) port_pick[p][i] = 1'b0;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    issue_valid   = '0;
    issue_dest    = '0;
    issue_rs1_val = '0;
    issue_rs2_val = '0;
    issue_opcode  = '0;
    issue_imm     = '0;
    issue_rob     = '0;
    issue_mask    = '0;
    issue_cnt     = '0;
    for (int p = 0; p < NUM_FU; p++) begin
      sel_idx[p]     = hold_idx_q[p];
      issue_valid[p] = hold_q[p] || (|port_pick[p]);
      if (!hold_q[p])
        for (int i = DEPTH - 1; i >= 0; i--)
          if (port_pick[p][i]) sel_idx[p] = IDX_W'(i);
      if (issue_valid[p]) begin
        issue_dest[p*PREG_W +: PREG_W]    = dest_q[sel_idx[p]];
        issue_rs1_val[p*DATA_W +: DATA_W] = rs1_val_q[sel_idx[p]];
        issue_rs2_val[p*DATA_W +: DATA_W] = rs2_val_q[sel_idx[p]];
        issue_opcode[p*7 +: 7]            = opcode_q[sel_idx[p]];
        issue_imm[p*DATA_W +: DATA_W]     = imm_q[sel_idx[p]];
        issue_rob[p*ROB_W +: ROB_W]       = rob_q[sel_idx[p]];
      end
      if (issue_valid[p] && issue_ready[p]) begin
        issue_mask[sel_idx[p]] = 1'b1;
        issue_cnt              = issue_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      for (int p = 0; p < NUM_FU; p++) hold_idx_q[p] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      valid_q    <= (valid_q & ~issue_mask) | alloc_mask;
      count_q    <= count_q + CNT_W'(alloc_fire) - issue_cnt;
      rs1_rdy_q  <= ((rs1_rdy_q | wake1) & ~alloc_mask) | (alloc_mask & {DEPTH{a_rs1_rdy}});
      rs2_rdy_q  <= ((rs2_rdy_q | wake2) & ~alloc_mask) | (alloc_mask & {DEPTH{a_rs2_rdy}});
      hold_q     <= issue_valid & ~issue_ready;
      hold_idx_q <= sel_idx;
    end
  end

  // NOTE: payload storage has no reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_mask[i]) begin
        fu_q[i]      <= alloc_fu;
        dest_q[i]    <= alloc_dest;
        rs1_tag_q[i] <= alloc_rs1;
        rs2_tag_q[i] <= alloc_rs2;
        rs1_val_q[i] <= a_rs1_val;
        rs2_val_q[i] <= a_rs2_val;
        opcode_q[i]  <= alloc_opcode;
        imm_q[i]     <= alloc_imm;
        rob_q[i]     <= alloc_rob;
      end else begin
        if (wake1[i]) rs1_val_q[i] <= cdb_val;
        if (wake2[i]) rs2_val_q[i] <= cdb_val;
      end
    end
  end

`ifdef ISSUE_QUEUE_AGE_SEL_EN
  // A new entry is younger than every other slot; stale bits of free slots are rewritten on reuse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (alloc_fire && !flush) begin
      for (int j = 0; j < DEPTH; j++)
        if (IDX_W'(j) != free_idx) begin
          age_q[j][free_idx] <= 1'b1;
          age_q[free_idx][j] <= 1'b0;
        end
    end
  end
`endif

endmodule

// File: tb/tb_issue_select_queue.sv
// Self-checking bench for issue_select_queue: directed scenarios plus randomized traffic
// compared every cycle against an index/sequence-number model of the queue.
`timescale 1ns/1ps
module tb_issue_select_queue;

  localparam int DEPTH  = 16;
  localparam int NUM_FU = 3;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;
  localparam int FU_W   = 2;
  localparam int CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     alloc_valid, alloc_ready;
  logic [PREG_W-1:0]        alloc_dest, alloc_rs1, alloc_rs2;
  logic                     alloc_rs1_rdy, alloc_rs2_rdy;
  logic [DATA_W-1:0]        alloc_rs1_val, alloc_rs2_val, alloc_imm;
  logic [6:0]               alloc_opcode;
  logic [ROB_W-1:0]         alloc_rob;
  logic [FU_W-1:0]          alloc_fu;
  logic                     cdb_valid;
  logic [PREG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]        cdb_val;
  logic [NUM_FU-1:0]        issue_valid, issue_ready;
  logic [NUM_FU*PREG_W-1:0] issue_dest;
  logic [NUM_FU*DATA_W-1:0] issue_rs1_val, issue_rs2_val, issue_imm;
  logic [NUM_FU*7-1:0]      issue_opcode;
  logic [NUM_FU*ROB_W-1:0]  issue_rob;
  logic                     flush, full;
  logic [CNT_W-1:0]         count;

  always #5 clk = ~clk;

  issue_select_queue #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dest(alloc_dest),
    .alloc_rs1(alloc_rs1), .alloc_rs2(alloc_rs2), .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
    .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val), .alloc_opcode(alloc_opcode),
    .alloc_imm(alloc_imm), .alloc_rob(alloc_rob), .alloc_fu(alloc_fu),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dest(issue_dest),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val), .issue_opcode(issue_opcode),
    .issue_imm(issue_imm), .issue_rob(issue_rob),
    .flush(flush), .count(count), .full(full)
  );

  typedef struct {
    bit          v;
    int          fu, dest, t1, t2, opc, rob, seq;
    bit          r1, r2;
    int unsigned v1, v2, imm;
  } ent_t;

  ent_t mq [DEPTH];
  bit   m_hold     [NUM_FU];
  int   m_hold_idx [NUM_FU];
  int   m_seq;
  int   n_checks, n_err;
  bit   cmp_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mq[i].v) n++;
    return n;
  endfunction

  // Entry a port must present: its held entry, else the lowest-index (or oldest) ready entry.
  function automatic int m_sel(input int p);
    int best = -1;
    if (m_hold[p]) return m_hold_idx[p];
    for (int i = 0; i < DEPTH; i++)
      if (mq[i].v && mq[i].r1 && mq[i].r2 && mq[i].fu == p) begin
`ifdef ISSUE_QUEUE_AGE_SEL_EN
        if (best < 0 || mq[i].seq < mq[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    return best;
  endfunction

  task automatic model_step();
    int sel [NUM_FU];
    int k = -1;
    if (!reset_n || flush) begin
      for (int i = 0; i < DEPTH; i++) mq[i].v = 1'b0;
      for (int p = 0; p < NUM_FU; p++) m_hold[p] = 1'b0;
      return;
    end
    for (int p = 0; p < NUM_FU; p++) sel[p] = m_sel(p);
    if (alloc_valid && m_count() < DEPTH)
      for (int i = DEPTH - 1; i >= 0; i--) if (!mq[i].v) k = i;
    for (int i = 0; i < DEPTH; i++)
      if (mq[i].v && cdb_valid) begin
        if (!mq[i].r1 && mq[i].t1 == int'(cdb_tag)) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_val; end
        if (!mq[i].r2 && mq[i].t2 == int'(cdb_tag)) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_val; end
      end
    for (int p = 0; p < NUM_FU; p++) begin
      if (sel[p] >= 0 && issue_ready[p]) mq[sel[p]].v = 1'b0;
      m_hold[p]     = (sel[p] >= 0) && !issue_ready[p];
      m_hold_idx[p] = sel[p];
    end
    if (k >= 0) begin
      mq[k].v    = 1'b1;
      mq[k].fu   = alloc_fu;
      mq[k].dest = alloc_dest;
      mq[k].t1   = alloc_rs1;
      mq[k].t2   = alloc_rs2;
      mq[k].opc  = alloc_opcode;
      mq[k].imm  = alloc_imm;
      mq[k].rob  = alloc_rob;
      mq[k].seq  = m_seq++;
      if (alloc_rs1 == 0)     begin mq[k].r1 = 1'b1; mq[k].v1 = 0; end
      else if (alloc_rs1_rdy) begin mq[k].r1 = 1'b1; mq[k].v1 = alloc_rs1_val; end
      else                    begin mq[k].r1 = cdb_valid && cdb_tag == alloc_rs1; mq[k].v1 = cdb_val; end
      if (alloc_rs2 == 0)     begin mq[k].r2 = 1'b1; mq[k].v2 = 0; end
      else if (alloc_rs2_rdy) begin mq[k].r2 = 1'b1; mq[k].v2 = alloc_rs2_val; end
      else                    begin mq[k].r2 = cdb_valid && cdb_tag == alloc_rs2; mq[k].v2 = cdb_val; end
    end
  endtask

  task automatic compare_all();
    int   n = m_count();
    int   s;
    ent_t e;
    check("alloc_ready", alloc_ready, n < DEPTH);
    check("full", full, n == DEPTH);
    check("count", count, n);
    for (int p = 0; p < NUM_FU; p++) begin
      s = m_sel(p);
      e = '{default: 0};
      if (s >= 0) e = mq[s];
      check($sformatf("issue_valid[%0d]", p), issue_valid[p], s >= 0);
      check($sformatf("issue_dest[%0d]", p), issue_dest[p*PREG_W +: PREG_W], e.dest);
      check($sformatf("issue_rs1_val[%0d]", p), issue_rs1_val[p*DATA_W +: DATA_W], e.v1);
      check($sformatf("issue_rs2_val[%0d]", p), issue_rs2_val[p*DATA_W +: DATA_W], e.v2);
      check($sformatf("issue_opcode[%0d]", p), issue_opcode[p*7 +: 7], e.opc);
      check($sformatf("issue_imm[%0d]", p), issue_imm[p*DATA_W +: DATA_W], e.imm);
      check($sformatf("issue_rob[%0d]", p), issue_rob[p*ROB_W +: ROB_W], e.rob);
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (cmp_en) compare_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic alloc_set(input int d, input int t1, input bit r1, input int unsigned v1,
                           input int t2, input bit r2, input int unsigned v2, input int fu);
    alloc_valid   = 1'b1;
    alloc_dest    = PREG_W'(d);
    alloc_rs1     = PREG_W'(t1);
    alloc_rs1_rdy = r1;
    alloc_rs1_val = v1;
    alloc_rs2     = PREG_W'(t2);
    alloc_rs2_rdy = r2;
    alloc_rs2_val = v2;
    alloc_fu      = FU_W'(fu);
    alloc_opcode  = 7'h33;
    alloc_imm     = 32'h100 + d;
    alloc_rob     = ROB_W'(d);
  endtask

  task automatic cdb(input int tag, input int unsigned val);
    cdb_valid = 1'b1;
    cdb_tag   = PREG_W'(tag);
    cdb_val   = val;
  endtask

  task automatic drain(input string name);
    int k = 0;
    issue_ready = '1;
    while (count != 0 && k < 60) begin tick(); k++; end
    check(name, count, 0);
  endtask

  initial begin
    idle();
    cdb_tag = '0; cdb_val = '0; issue_ready = '0;
    reset_n = 1'b0;
    alloc_set(1, 0, 1'b0, 0, 0, 1'b0, 0, 0);  // must be ignored while in reset
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    check("rst alloc_ready", alloc_ready, 1);
    check("rst full", full, 0);
    check("rst count", count, 0);
    check("rst issue_valid", issue_valid, 0);
    check("rst issue_dest", issue_dest, 0);
    reset_n = 1'b1;
    idle();

    // Ready operands issue the cycle after allocation.
    issue_ready = '1;
    alloc_set(1, 2, 1'b1, 42, 3, 1'b1, 17, 0);
    tick(); alloc_valid = 1'b0;
    check("add issue_valid", issue_valid[0], 1);
    check("add rs1_val", issue_rs1_val[31:0], 42);
    check("add rs2_val", issue_rs2_val[31:0], 17);
    check("add dest", issue_dest[5:0], 1);
    check("add count", count, 1);
    tick();
    check("add count after", count, 0);

    // Wakeup from a later CDB broadcast; tag 0 reads as zero.
    alloc_set(4, 5, 1'b0, 0, 0, 1'b1, 555, 0);
    tick(); alloc_valid = 1'b0;
    check("wake waiting", issue_valid[0], 0);
    cdb(5, 99);
    tick(); cdb_valid = 1'b0;
    check("wake issue_valid", issue_valid[0], 1);
    check("wake rs1_val", issue_rs1_val[31:0], 99);
    check("tag0 rs2_val", issue_rs2_val[31:0], 0);
    tick();

    // CDB hit during allocation.
    alloc_set(6, 0, 1'b0, 0, 7, 1'b0, 0, 0);
    cdb(7, 11);
    tick(); idle();
    check("bypass issue_valid", issue_valid[0], 1);
    check("bypass rs2_val", issue_rs2_val[31:0], 11);
    tick();

    // Fill to capacity, then one handshake reopens allocation a cycle later.
    issue_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_set(10 + i, 9, 1'b0, 0, 0, 1'b1, 0, i % NUM_FU);
      tick();
    end
    alloc_valid = 1'b0;
    check("fill full", full, 1);
    check("fill alloc_ready", alloc_ready, 0);
    check("fill count", count, DEPTH);
    cdb(9, 3);
    tick(); cdb_valid = 1'b0;
    alloc_set(50, 0, 1'b1, 0, 0, 1'b1, 0, 0);
    issue_ready = 3'b001;
    check("fill same-cycle alloc_ready", alloc_ready, 0);
    tick(); alloc_valid = 1'b0; issue_ready = '0;
    check("fill reopen alloc_ready", alloc_ready, 1);
    check("fill reopen count", count, DEPTH - 1);
    drain("fill drain");

    // A (slot 3) older than B (slot 0, reused) on port 1.
    issue_ready = 3'b001;
    alloc_set(20, 13, 1'b0, 0, 0, 1'b1, 0, 0); tick();
    alloc_set(21, 10, 1'b0, 0, 0, 1'b1, 0, 2); tick();
    alloc_set(22, 10, 1'b0, 0, 0, 1'b1, 0, 2); tick();
    alloc_set(23, 12, 1'b0, 0, 0, 1'b1, 0, 1); tick();
    alloc_valid = 1'b0;
    cdb(13, 1); tick(); cdb_valid = 1'b0;
    tick();
    alloc_set(24, 12, 1'b0, 0, 0, 1'b1, 0, 1); tick(); alloc_valid = 1'b0;
    cdb(12, 2); tick(); cdb_valid = 1'b0;
`ifdef ISSUE_QUEUE_AGE_SEL_EN
    check("age pick dest", issue_dest[PREG_W +: PREG_W], 23);
`else
    check("index pick dest", issue_dest[PREG_W +: PREG_W], 24);
`endif
    tick();
`ifdef ISSUE_QUEUE_AGE_SEL_EN
    check("stall hold dest", issue_dest[PREG_W +: PREG_W], 23);
`else
    check("stall hold dest", issue_dest[PREG_W +: PREG_W], 24);
`endif
    cdb(10, 4); tick(); cdb_valid = 1'b0;
    drain("select drain");

    // Flush overrides allocation and issue.
    issue_ready = '0;
    for (int i = 0; i < 5; i++) begin
      alloc_set(30 + i, 0, 1'b1, 0, 0, 1'b1, 0, i % NUM_FU);
      tick();
    end
    alloc_valid = 1'b0;
    check("pre-flush count", count, 5);
    flush = 1'b1; issue_ready = '1;
    alloc_set(40, 0, 1'b1, 0, 0, 1'b1, 0, 0);
    tick(); idle();
    check("flush count", count, 0);
    check("flush issue_valid", issue_valid, 0);
    tick();
    check("flush no alloc", count, 0);

    // Reset in the middle of operation.
    issue_ready = '0;
    for (int i = 0; i < 3; i++) begin alloc_set(45 + i, 0, 1'b1, 0, 0, 1'b1, 0, 1); tick(); end
    reset_n = 1'b0;
    tick(); tick();
    check("midrst count", count, 0);
    check("midrst alloc_ready", alloc_ready, 1);
    check("midrst issue_valid", issue_valid, 0);
    reset_n = 1'b1;
    idle();

    // Randomized traffic with alternating back-pressure phases.
    for (int c = 0; c < 4000; c++) begin
      int rp = ((c / 500) % 2 == 1) ? 25 : 85;
      alloc_valid   = ($urandom_range(0, 99) < 60);
      alloc_dest    = PREG_W'($urandom_range(0, 63));
      alloc_rs1     = PREG_W'($urandom_range(0, 7));
      alloc_rs2     = PREG_W'($urandom_range(0, 7));
      alloc_rs1_rdy = 1'($urandom_range(0, 1));
      alloc_rs2_rdy = 1'($urandom_range(0, 1));
      alloc_rs1_val = $urandom;
      alloc_rs2_val = $urandom;
      alloc_opcode  = 7'($urandom_range(0, 127));
      alloc_imm     = $urandom;
      alloc_rob     = ROB_W'($urandom_range(0, 63));
      alloc_fu      = FU_W'($urandom_range(0, NUM_FU - 1));
      cdb_valid     = 1'($urandom_range(0, 1));
      cdb_tag       = PREG_W'($urandom_range(1, 7));
      cdb_val       = $urandom;
      for (int p = 0; p < NUM_FU; p++) issue_ready[p] = ($urandom_range(0, 99) < rp);
      flush         = ($urandom_range(0, 79) == 0);
      reset_n       = !($urandom_range(0, 399) == 0);
      tick();
    end
    idle();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
